// File: rtl/spi_flash_read.sv
// rtl/spi_flash_read.sv - one-shot SPI READ DATA BYTES master for an M25P16-class NOR flash
// Optional SPI_FAST_READ_EN: FAST_READ (0x0B) with one dummy byte and a 2-cycle SPI bit.
module spi_flash_read #(
    parameter logic [7:0]  BYTE_MAX    = 8'd10,
    parameter logic [7:0]  SECTOR_ADDR = 8'h00,
    parameter logic [7:0]  PAGE_ADDR   = 8'h00,
    parameter logic [7:0]  BYTE_ADDR   = 8'h00,
    parameter logic [15:0] STARTUP_CYC = 16'd500
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       spi_miso,
    output logic       spi_sclk,
    output logic       spi_cs,
    output logic       spi_mosi,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       done
);

`ifdef SPI_FAST_READ_EN
    localparam int             TX_W    = 40;
    localparam logic [1:0]     PH_LAST = 2'd1;
    localparam logic [1:0]     PH_HIGH = 2'd1;
    localparam logic [TX_W-1:0] TX_INIT = {8'h0B, SECTOR_ADDR, PAGE_ADDR, BYTE_ADDR, 8'h00};
`else
    localparam int             TX_W    = 32;
    localparam logic [1:0]     PH_LAST = 2'd3;
    localparam logic [1:0]     PH_HIGH = 2'd2;
    localparam logic [TX_W-1:0] TX_INIT = {8'h03, SECTOR_ADDR, PAGE_ADDR, BYTE_ADDR};
`endif

    typedef enum logic [2:0] {
        S_WAIT,
        S_CS_SETUP,
        S_CMD,
        S_ADDR,
        S_DUMMY,
        S_READ,
        S_CS_HOLD,
        S_DONE
    } state_t;

    state_t          state, state_n;
    logic [15:0]     wait_cnt, wait_n, wait_inc;
    logic [1:0]      cyc_cnt, cyc_n;
    logic [1:0]      phase, phase_n;
    logic [4:0]      bit_cnt, bit_n;
    logic [TX_W-1:0] tx_shift, tx_n;
    logic [7:0]      rx_shift, rx_n;
    logic [7:0]      byte_cnt, byte_n, byte_inc;
    logic [7:0]      rd_data_n;
    logic            rd_valid_n;
    logic            shifting_n;
    logic            cs_n, sclk_n, mosi_n, done_n;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state    <= S_WAIT;
            wait_cnt <= '0;
            cyc_cnt  <= '0;
            phase    <= '0;
            bit_cnt  <= '0;
            tx_shift <= '0;
            rx_shift <= '0;
            byte_cnt <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            spi_cs   <= 1'b1;
            spi_sclk <= 1'b0;
            spi_mosi <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            wait_cnt <= wait_n;
            cyc_cnt  <= cyc_n;
            phase    <= phase_n;
            bit_cnt  <= bit_n;
            tx_shift <= tx_n;
            rx_shift <= rx_n;
            byte_cnt <= byte_n;
            rd_data  <= rd_data_n;
            rd_valid <= rd_valid_n;
            spi_cs   <= cs_n;
            spi_sclk <= sclk_n;
            spi_mosi <= mosi_n;
            done     <= done_n;
        end
    end

    always_comb begin
        state_n    = state;
        wait_n     = wait_cnt;
        cyc_n      = cyc_cnt;
        phase_n    = phase;
        bit_n      = bit_cnt;
        tx_n       = tx_shift;
        rx_n       = rx_shift;
        byte_n     = byte_cnt;
        rd_data_n  = rd_data;
        rd_valid_n = 1'b0;
        wait_inc   = wait_cnt + 16'd1;
        byte_inc   = byte_cnt + 8'd1;

        case (state)
            S_WAIT: begin
                if (wait_inc >= STARTUP_CYC) begin
                    state_n = S_CS_SETUP;
                    wait_n  = '0;
                end else begin
                    wait_n = wait_inc;
                end
            end
            S_CS_SETUP: begin
                if (cyc_cnt == 2'd3) begin
                    state_n = S_CMD;
                    cyc_n   = '0;
                    phase_n = '0;
                    bit_n   = '0;
                    tx_n    = TX_INIT;
                end else begin
                    cyc_n = cyc_cnt + 2'd1;
                end
            end
            S_CMD, S_ADDR, S_DUMMY, S_READ: begin
                if (phase != PH_LAST) begin
                    phase_n = phase + 2'd1;
                end else begin
                    // End of the high half: next bit starts, MISO is sampled here.
                    phase_n = '0;
                    bit_n   = bit_cnt + 5'd1;
                    tx_n    = {tx_shift[TX_W-2:0], 1'b0};
                    case (state)
                        S_CMD: begin
                            if (bit_cnt == 5'd7) begin
                                state_n = S_ADDR;
                                bit_n   = '0;
                            end
                        end
                        S_ADDR: begin
                            if (bit_cnt == 5'd23) begin
`ifdef SPI_FAST_READ_EN
                                state_n = S_DUMMY;
`else
                                state_n = S_READ;
`endif
                                bit_n   = '0;
                            end
                        end
                        S_DUMMY: begin
                            if (bit_cnt == 5'd7) begin
                                state_n = S_READ;
                                bit_n   = '0;
                            end
                        end
                        default: begin
                            rx_n = {rx_shift[6:0], spi_miso};
                            if (bit_cnt[2:0] == 3'd7) begin
                                bit_n      = '0;
                                rd_data_n  = rx_n;
                                rd_valid_n = 1'b1;
                                byte_n     = byte_inc;
                                if (byte_inc == BYTE_MAX) begin
                                    state_n = S_CS_HOLD;
                                    rx_n    = '0;
                                end
                            end
                        end
                    endcase
                end
            end
            S_CS_HOLD: begin
                if (cyc_cnt == 2'd3) begin
                    state_n = S_DONE;
                    cyc_n   = '0;
                end else begin
                    cyc_n = cyc_cnt + 2'd1;
                end
            end
            default: begin
                state_n = S_DONE;
            end
        endcase

        // Pins are registered from the next-state decode so they line up with the state.
        shifting_n = (state_n == S_CMD) || (state_n == S_ADDR) ||
                     (state_n == S_DUMMY) || (state_n == S_READ);
        cs_n   = !(shifting_n || (state_n == S_CS_SETUP) || (state_n == S_CS_HOLD));
        sclk_n = shifting_n && (phase_n >= PH_HIGH);
        mosi_n = ((state_n == S_CMD) || (state_n == S_ADDR) || (state_n == S_DUMMY)) ?
                 tx_n[TX_W-1] : 1'b0;
        done_n = (state_n == S_DONE);
    end

endmodule

// File: tb/tb_spi_flash_read.sv
// tb/tb_spi_flash_read.sv - directed bench for spi_flash_read with a behavioural page-pattern flash
`timescale 1ns/1ps
module tb_spi_flash_read;

`ifdef SPI_FAST_READ_EN
    localparam int          HDR     = 40;
    localparam logic [39:0] HDR_EXP = 40'h0B_00_00_00_00;
    localparam int          PER_EXP = 40;
    localparam int          CSL10   = 248;
    localparam int          CSL1    = 104;
`else
    localparam int          HDR     = 32;
    localparam logic [39:0] HDR_EXP = 40'h00_03_00_00_00;
    localparam int          PER_EXP = 80;
    localparam int          CSL10   = 456;
    localparam int          CSL1    = 168;
`endif

    logic       clk = 1'b0;
    logic [2:0] rst = 3'b111;
    int         tests = 0;
    int         fails = 0;

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Instance 0: defaults; 1: BYTE_ADDR=FA; 2: BYTE_MAX=1.
    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam logic [7:0] BM = (g == 2) ? 8'd1 : 8'd10;
        localparam logic [7:0] BA = (g == 1) ? 8'hFA : 8'h00;

        logic       cs, sclk, mosi, valid, dn;
        logic       miso = 1'b0;
        logic [7:0] data;

        int          bitn = 0;
        logic [39:0] hdr = '0;
        logic [39:0] hdr_cap = '0;
        int          nrise = 0;
        time         t_first = 0;
        time         per = 0;
        int          edges_hi = 0;
        int          nvalid = 0;
        int          cs_low = 0;
        int          vrun = 0;
        int          vmax = 0;
        logic [7:0]  got [16];

        spi_flash_read #(.BYTE_MAX(BM), .BYTE_ADDR(BA)) u_dut (
            .sys_clk (clk),
            .sys_rst (rst[g]),
            .spi_miso(miso),
            .spi_sclk(sclk),
            .spi_cs  (cs),
            .spi_mosi(mosi),
            .rd_data (data),
            .rd_valid(valid),
            .done    (dn)
        );

        always @(posedge cs) begin
            bitn = 0;
            hdr  = '0;
        end

        always @(posedge sclk) begin
            if (cs) begin
                edges_hi++;
            end else begin
                if (nrise == 0) t_first = $time;
                else if (nrise == 1) per = $time - t_first;
                nrise++;
                if (bitn < HDR) hdr = {hdr[38:0], mosi};
                bitn++;
                if (bitn == HDR) hdr_cap = hdr;
            end
        end

        // Mode 0 flash: data changes on the falling edge; every page holds 00..FF.
        always @(negedge sclk) begin
            if (!cs && bitn >= HDR) begin
                int         k;
                logic [7:0] a, b;
                k = bitn - HDR;
                a = (HDR == 40) ? hdr[15:8] : hdr[7:0];
                b = a + 8'(k / 8);
                miso = b[3'(7 - (k % 8))];
            end
        end

        always @(negedge clk) begin
            if (rst[g]) begin
                nvalid = 0;
                cs_low = 0;
                vrun   = 0;
                vmax   = 0;
            end else begin
                if (!cs) cs_low++;
                if (valid) begin
                    if (nvalid < 16) got[nvalid] = data;
                    nvalid++;
                    vrun++;
                    if (vrun > vmax) vmax = vrun;
                end else begin
                    vrun = 0;
                end
            end
        end
    end

    initial begin
        int  n;
        logic ok;

        repeat (3) @(posedge clk);
        #1;
        check("rst_cs",    64'(g_dut[0].cs),    64'd1);
        check("rst_sclk",  64'(g_dut[0].sclk),  64'd0);
        check("rst_mosi",  64'(g_dut[0].mosi),  64'd0);
        check("rst_data",  64'(g_dut[0].data),  64'd0);
        check("rst_valid", 64'(g_dut[0].valid), 64'd0);
        check("rst_done",  64'(g_dut[0].dn),    64'd0);
        #1 rst = 3'b000;

        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            if (g_dut[0].dn && g_dut[1].dn && g_dut[2].dn) begin
                ok = 1'b1;
                break;
            end
        end
        check("all_done", 64'(ok), 64'd1);

        check("d0_count",  64'(g_dut[0].nvalid), 64'd10);
        for (int i = 0; i < 10; i++)
            check($sformatf("d0_byte%0d", i), 64'(g_dut[0].got[i]), 64'(i));
        check("d0_cs_high",   64'(g_dut[0].cs),       64'd1);
        check("d0_cs_low",    64'(g_dut[0].cs_low),   64'(CSL10));
        check("d0_header",    64'(g_dut[0].hdr_cap),  64'(HDR_EXP));
        check("d0_period",    64'(g_dut[0].per),      64'(PER_EXP));
        check("d0_edges_hi",  64'(g_dut[0].edges_hi), 64'd0);
        check("d0_pulse_len", 64'(g_dut[0].vmax),     64'd1);
        check("d0_mosi_idle", 64'(g_dut[0].mosi),     64'd0);

        check("d1_count", 64'(g_dut[1].nvalid), 64'd10);
        for (int i = 0; i < 10; i++)
            check($sformatf("d1_byte%0d", i), 64'(g_dut[1].got[i]), 64'(8'(8'hFA + i)));

        check("d2_count",  64'(g_dut[2].nvalid), 64'd1);
        check("d2_byte0",  64'(g_dut[2].got[0]), 64'h00);
        check("d2_cs_low", 64'(g_dut[2].cs_low), 64'(CSL1));
        check("d2_done",   64'(g_dut[2].dn),     64'd1);

        // Restart instance 0, then reset it in the middle of its fifth byte.
        @(posedge clk);
        #2 rst[0] = 1'b1;
        @(posedge clk);
        #2 rst[0] = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            #1;
            if (g_dut[0].nvalid == 4) begin
                ok = 1'b1;
                break;
            end
        end
        check("reach_byte5", 64'(ok), 64'd1);
        repeat (8) @(posedge clk);
        #2 rst[0] = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_cs",    64'(g_dut[0].cs),    64'd1);
        check("mid_rst_sclk",  64'(g_dut[0].sclk),  64'd0);
        check("mid_rst_valid", 64'(g_dut[0].valid), 64'd0);
        check("mid_rst_data",  64'(g_dut[0].data),  64'd0);
        #1 rst[0] = 1'b0;

        n = 0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk);
            #1;
            n++;
            if (!g_dut[0].cs) break;
        end
        check("startup_wait", 64'(n), 64'd500);

        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            #1;
            if (g_dut[0].dn) begin
                ok = 1'b1;
                break;
            end
        end
        check("rerun_done",  64'(ok),               64'd1);
        check("rerun_count", 64'(g_dut[0].nvalid),  64'd10);
        for (int i = 0; i < 10; i++)
            check($sformatf("rerun_byte%0d", i), 64'(g_dut[0].got[i]), 64'(i));
        check("rerun_cs_low", 64'(g_dut[0].cs_low), 64'(CSL10));
        check("rerun_cs",     64'(g_dut[0].cs),     64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/spi_flash_read.md
# spi_flash_read

SPI master that runs one READ DATA BYTES transaction against an M25P16-class serial NOR flash after reset. It waits out the flash power-up time, asserts chip select, and shifts out the read command and a 24-bit address. It then clocks in `BYTE_MAX` bytes, presenting each as a parallel byte with a one-cycle strobe. It sits between the system clock domain and the external flash pins.

## Interface
- `BYTE_MAX`, 8'd10, number of bytes to read (1..255).
- `SECTOR_ADDR`, 8'h00, address bits [23:16].
- `PAGE_ADDR`, 8'h00, address bits [15:8].
- `BYTE_ADDR`, 8'h00, address bits [7:0].
- `STARTUP_CYC`, 16'd500, sys_clk cycles to wait after reset before CS falls (10 us at 50 MHz).
- `sys_clk`  in  1  system clock, 50 MHz; all logic on its rising edge.
- `sys_rst`  in  1  one clock; reset is synchronous and active-high.
- `spi_miso`  in  1  flash serial data out.
- `spi_sclk`  out  1  SPI clock, mode 0 (idle low).
- `spi_cs`  out  1  flash chip select, active low.
- `spi_mosi`  out  1  flash serial data in.
- `rd_data`  out  8  last received byte, MSB first as shifted.
- `rd_valid`  out  1  one-cycle strobe when `rd_data` updates.
- `done`  out  1  level, high once the transaction finishes, until reset.

## Operation
- Reset values: `spi_cs`=1, `spi_sclk`=0, `spi_mosi`=0, `rd_data`=0, `rd_valid`=0, `done`=0, state WAIT, all counters 0.
- FSM states and transitions:
  - WAIT: count `STARTUP_CYC` cycles, then go to CS_SETUP.
  - CS_SETUP: `spi_cs`=0 for 4 cycles, then go to CMD.
  - CMD: 8 bits of 8'h03, then go to ADDR.
  - ADDR: 24 bits {SECTOR_ADDR, PAGE_ADDR, BYTE_ADDR}, then go to READ.
  - READ: `BYTE_MAX`×8 bits, then go to CS_HOLD.
  - CS_HOLD: 4 cycles with sclk low, then `spi_cs`=1 and go to DONE.
  - DONE: terminal; `done`=1. No further SPI activity until reset.
- All shifts are MSB first. `spi_mosi` is 0 during READ and outside CMD/ADDR.
- Bits are assembled in an 8-bit shift register. On every 8th received bit, `rd_data` is loaded with the completed byte and `rd_valid` pulses.
- The byte counter is 8 bits wide. READ ends when the count equals `BYTE_MAX`, with no wrap. The flash itself wraps its internal address past 0x1FFFFF; the block does not track this.
- A synchronous reset in any state, including mid-byte, returns everything to reset values on the next edge. CS is released immediately and any partial byte is discarded.

## Timing
- One SPI bit spans 4 sys_clk cycles (phase counter 0..3), giving SCLK = sys_clk/4 = 12.5 MHz. This is below the M25P16 READ limit of 20 MHz.
- Phase 0: `spi_mosi` updates, `spi_sclk`=0.
- Phase 1: `spi_sclk`=0.
- Phase 2: `spi_sclk`=1 (rising edge, where the flash samples).
- Phase 3: `spi_sclk`=1. `spi_miso` is registered at the end of phase 3.
- The first bit of CMD starts on the cycle after CS_SETUP ends.
- From CS low to the first READ bit: 4 + 32×4 = 132 cycles.
- `rd_valid` for byte k (k=0..BYTE_MAX-1) asserts 1 cycle after the phase-3 sample of bit 7 of that byte.
- `done` rises 4 cycles after the last data bit's phase 3, in the same cycle that `spi_cs` returns high.
- Total transaction with CS low: 4 + (32 + 8×BYTE_MAX)×4 + 4 cycles; for the defaults this is 456 cycles.

## Configuration
- `SPI_FAST_READ_EN`
  - Defined: the command is 8'h0B (FAST_READ) and one dummy byte (8'h00) is sent after the address, before READ. SCLK = sys_clk/2 (2-cycle bit: phase 0 low/drive, phase 1 high/sample).
  - Undefined: 8'h03 command, no dummy byte, sys_clk/4 timing as above.

## Test plan
- Defaults, flash preloaded so each page holds 00..FF, address 0x000000 → ten `rd_valid` pulses with `rd_data` = 00,01,…,09; `done`=1; `spi_cs` is high afterwards.
- Check MOSI during CMD/ADDR with defaults → bit stream 0x03,0x00,0x00,0x00 on SCLK rising edges; SCLK period 80 ns; no SCLK edges while `spi_cs`=1.
- `BYTE_ADDR`=8'hFA, `BYTE_MAX`=10 → reads FA,FB,…,FF,00,01,02,03 (page-content wrap provided by the flash).
- `BYTE_MAX`=1 → exactly one `rd_valid` with data 00; CS low for 168 cycles.
- Assert `sys_rst` for 1 cycle during the 5th data byte → `spi_cs`=1 and `spi_sclk`=0 on the next edge, then `STARTUP_CYC` wait, then the full transaction restarts and produces 00..09 again.
- With `SPI_FAST_READ_EN` defined → MOSI stream 0x0B,0x00,0x00,0x00,0x00; SCLK period 40 ns; data 00..09.
